// File: rtl/mtr_pkg.sv
// Shared types and constants for the meter interrupt arbiter.
package mtr_pkg;

    typedef enum logic [1:0] {IDLE, REQ, SERVE} mtr_arb_state_t;

    localparam int SRC_TIME  = 0;
    localparam int SRC_PERF  = 1;
    localparam int SRC_EBOX  = 2;
    localparam int SRC_CACHE = 3;

    localparam int PIA_W = 3;
    localparam int SEL_W = 2;

    // One-hot PI request vector for a level; level 0 yields no request.
    function automatic logic [1:7] pi_onehot(input logic [0:PIA_W-1] lvl);
        logic [1:7] v;
        v = '0;
        for (int i = 1; i <= 7; i++) begin
            v[i] = (int'(lvl) == i);
        end
        return v;
    endfunction

endpackage

// File: rtl/mtr_prio_enc.sv
// Fixed-priority encoder: counters in index order ahead of the interval timer.
module mtr_prio_enc
    import mtr_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [0:NSRC-1]  pend,
    input  logic             intv,
    output logic             any,
    output logic             vector,
    output logic [0:SEL_W-1] sel
);

    logic found;

    always_comb begin
        found  = 1'b0;
        sel    = '0;
        vector = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && !found) begin
                found = 1'b1;
                sel   = SEL_W'(i);
            end
        end
        // The timer only wins when no counter is pending; its selection reads as 00.
        vector = !found && intv;
        any    = found || intv;
    end

endmodule

// File: rtl/mtr_intr_arb.sv
// Meter interrupt arbiter: latches overflow events, requests a PI level, holds the
// selected source until service completes. Optional overrun flag: MTR_LOST_DETECT_EN.
module mtr_intr_arb
    import mtr_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [0:NSRC-1]  OVF_SET,
    input  logic             INTERVAL_DONE,
    input  logic [0:PIA_W-1] PIA,
    input  logic             HONOR,
    input  logic             SVC_DONE,
    input  logic             CLR_LOST,
    output logic [1:7]       PI_REQ,
    output logic             INTERRUPT_REQ,
    output logic             VECTOR_REQ,
    output logic [0:SEL_W-1] INCR_SEL,
    output logic             BUSY,
    output logic [0:NSRC-1]  PENDING,
    output logic             LOST
);

    mtr_arb_state_t   state;
    logic             enc_any;
    logic             enc_vec;
    logic [0:SEL_W-1] enc_sel;
    logic             svc_end;
    logic [0:NSRC-1]  clr_vec;

    mtr_prio_enc #(.NSRC(NSRC)) u_prio (
        .pend   (PENDING),
        .intv   (INTERVAL_DONE),
        .any    (enc_any),
        .vector (enc_vec),
        .sel    (enc_sel)
    );

    assign svc_end = (state == SERVE) && SVC_DONE;

    // Only the captured counter clears; the interval timer is cleared externally.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_vec[i] = svc_end && !VECTOR_REQ && (INCR_SEL == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            PENDING <= '0;
        end else begin
            PENDING <= (PENDING & ~clr_vec) | OVF_SET;
        end
    end

`ifdef MTR_LOST_DETECT_EN
    logic lost_hit;
    assign lost_hit = |(OVF_SET & PENDING & ~clr_vec);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            LOST <= 1'b0;
        end else begin
            LOST <= lost_hit || (LOST && !CLR_LOST);
        end
    end
`else
    logic unused_clr_lost;
    assign unused_clr_lost = CLR_LOST;
    assign LOST            = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            PI_REQ        <= '0;
            INTERRUPT_REQ <= 1'b0;
            VECTOR_REQ    <= 1'b0;
            INCR_SEL      <= '0;
            BUSY          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_any && (PIA != '0)) begin
                        state         <= REQ;
                        PI_REQ        <= pi_onehot(PIA);
                        INTERRUPT_REQ <= 1'b1;
                    end
                end
                REQ: begin
                    if ((PIA == '0) || !enc_any) begin
                        state         <= IDLE;
                        PI_REQ        <= '0;
                        INTERRUPT_REQ <= 1'b0;
                    end else if (HONOR) begin
                        state         <= SERVE;
                        PI_REQ        <= '0;
                        INTERRUPT_REQ <= 1'b0;
                        BUSY          <= 1'b1;
                        INCR_SEL      <= enc_sel;
                        VECTOR_REQ    <= enc_vec;
                    end else begin
                        PI_REQ        <= pi_onehot(PIA);
                    end
                end
                SERVE: begin
                    if (SVC_DONE) begin
                        state      <= IDLE;
                        BUSY       <= 1'b0;
                        INCR_SEL   <= '0;
                        VECTOR_REQ <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_intr_arb.sv
// Directed-vector bench for the meter interrupt arbiter.
module tb_mtr_intr_arb;

    logic       clk;
    logic       RESET_N;
    logic [0:3] OVF_SET;
    logic       INTERVAL_DONE;
    logic [0:2] PIA;
    logic       HONOR;
    logic       SVC_DONE;
    logic       CLR_LOST;
    logic [1:7] PI_REQ;
    logic       INTERRUPT_REQ;
    logic       VECTOR_REQ;
    logic [0:1] INCR_SEL;
    logic       BUSY;
    logic [0:3] PENDING;
    logic       LOST;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MTR_LOST_DETECT_EN
    localparam logic LOST_EXP = 1'b1;
`else
    localparam logic LOST_EXP = 1'b0;
`endif

    mtr_intr_arb #(.NSRC(4)) dut (
        .clk           (clk),
        .RESET_N       (RESET_N),
        .OVF_SET       (OVF_SET),
        .INTERVAL_DONE (INTERVAL_DONE),
        .PIA           (PIA),
        .HONOR         (HONOR),
        .SVC_DONE      (SVC_DONE),
        .CLR_LOST      (CLR_LOST),
        .PI_REQ        (PI_REQ),
        .INTERRUPT_REQ (INTERRUPT_REQ),
        .VECTOR_REQ    (VECTOR_REQ),
        .INCR_SEL      (INCR_SEL),
        .BUSY          (BUSY),
        .PENDING       (PENDING),
        .LOST          (LOST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 10 && !INTERRUPT_REQ; i++) step();
        chk(tag, INTERRUPT_REQ, 1'b1);
    endtask

    task automatic serve(input string tag, input logic [1:0] exp_sel, input logic exp_vec);
        wait_req({tag, "_req"});
        HONOR = 1'b1;
        step();
        HONOR = 1'b0;
        chk({tag, "_sel"}, INCR_SEL, exp_sel);
        chk({tag, "_vec"}, VECTOR_REQ, exp_vec);
        chk({tag, "_busy"}, BUSY, 1'b1);
        SVC_DONE = 1'b1;
        step();
        SVC_DONE = 1'b0;
        chk({tag, "_idle"}, BUSY, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0; OVF_SET = '0; INTERVAL_DONE = 1'b0; PIA = '0;
        HONOR = 1'b0; SVC_DONE = 1'b0; CLR_LOST = 1'b0;
        repeat (2) step();
        chk("rst_pireq", PI_REQ, 7'b0);
        chk("rst_intr", INTERRUPT_REQ, 1'b0);
        chk("rst_vec", VECTOR_REQ, 1'b0);
        chk("rst_sel", INCR_SEL, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_pend", PENDING, 4'b0000);
        chk("rst_lost", LOST, 1'b0);
        RESET_N = 1'b1;
        step();

        // Single EBOX service at level 3
        PIA = 3'd3; OVF_SET[2] = 1'b1;
        step();
        OVF_SET = '0;
        chk("t1_pend", PENDING, 4'b0010);
        chk("t1_noreq_yet", PI_REQ, 7'b0);
        step();
        chk("t1_pireq", PI_REQ, 7'b0010000);
        chk("t1_intr", INTERRUPT_REQ, 1'b1);
        HONOR = 1'b1;
        step();
        HONOR = 1'b0;
        chk("t1_sel", INCR_SEL, 2'b10);
        chk("t1_vec", VECTOR_REQ, 1'b0);
        chk("t1_busy", BUSY, 1'b1);
        chk("t1_pireq_off", PI_REQ, 7'b0);
        SVC_DONE = 1'b1;
        step();
        SVC_DONE = 1'b0;
        chk("t1_pend_clr", PENDING, 4'b0000);
        chk("t1_busy_clr", BUSY, 1'b0);
        step();
        chk("t1_stay_idle", INTERRUPT_REQ, 1'b0);

        // All four counters plus interval timer, served in priority order
        PIA = 3'd7; OVF_SET = 4'b1111; INTERVAL_DONE = 1'b1;
        step();
        OVF_SET = '0;
        chk("t2_pend", PENDING, 4'b1111);
        serve("t2_time", 2'b00, 1'b0);
        serve("t2_perf", 2'b01, 1'b0);
        serve("t2_ebox", 2'b10, 1'b0);
        serve("t2_cache", 2'b11, 1'b0);
        serve("t2_intv", 2'b00, 1'b1);
        INTERVAL_DONE = 1'b0;
        step(); step();
        chk("t2_done_intr", INTERRUPT_REQ, 1'b0);
        chk("t2_done_pend", PENDING, 4'b0000);

        // PIA=0 suppresses requests; level change and withdrawal during REQ
        PIA = 3'd0; OVF_SET[0] = 1'b1;
        step();
        OVF_SET = '0;
        step(); step();
        chk("t3_pia0_pireq", PI_REQ, 7'b0);
        chk("t3_pia0_pend", PENDING, 4'b1000);
        PIA = 3'd5;
        step();
        chk("t3_pia5", PI_REQ, 7'b0000100);
        PIA = 3'd6;
        step();
        chk("t3_pia6", PI_REQ, 7'b0000010);
        PIA = 3'd0;
        step();
        chk("t3_withdraw", INTERRUPT_REQ, 1'b0);
        chk("t3_withdraw_pi", PI_REQ, 7'b0);
        step();
        chk("t3_pend_kept", PENDING, 4'b1000);
        PIA = 3'd1;
        serve("t3_time", 2'b00, 1'b0);
        chk("t3_pend_clr", PENDING, 4'b0000);

        // Higher-priority arrival during CACHE service does not disturb selection
        PIA = 3'd2; OVF_SET[3] = 1'b1;
        step();
        OVF_SET = '0;
        wait_req("t4_req");
        HONOR = 1'b1;
        step();
        HONOR = 1'b0;
        chk("t4_sel", INCR_SEL, 2'b11);
        OVF_SET[0] = 1'b1;
        step();
        OVF_SET = '0;
        chk("t4_sel_hold", INCR_SEL, 2'b11);
        chk("t4_pend", PENDING, 4'b1001);
        chk("t4_no_pireq", PI_REQ, 7'b0);
        SVC_DONE = 1'b1;
        step();
        SVC_DONE = 1'b0;
        chk("t4_pend_after", PENDING, 4'b1000);
        serve("t4_next", 2'b00, 1'b0);

        // Overrun detection and coincident set/clear
        OVF_SET[1] = 1'b1;
        step();
        OVF_SET = '0;
        chk("t5_lost_first", LOST, 1'b0);
        OVF_SET[1] = 1'b1;
        step();
        OVF_SET = '0;
        chk("t5_lost", LOST, LOST_EXP);
        chk("t5_pend", PENDING, 4'b0100);
        CLR_LOST = 1'b1;
        step();
        CLR_LOST = 1'b0;
        chk("t5_lost_clr", LOST, 1'b0);
        wait_req("t5_req");
        HONOR = 1'b1;
        step();
        HONOR = 1'b0;
        chk("t5_sel", INCR_SEL, 2'b01);
        SVC_DONE = 1'b1; OVF_SET[1] = 1'b1;
        step();
        SVC_DONE = 1'b0; OVF_SET = '0;
        chk("t5_coinc_pend", PENDING, 4'b0100);
        chk("t5_coinc_lost", LOST, 1'b0);
        serve("t5_again", 2'b01, 1'b0);
        chk("t5_pend_clr", PENDING, 4'b0000);

        // Asynchronous reset while in SERVE
        OVF_SET[2] = 1'b1;
        step();
        OVF_SET = '0;
        wait_req("t6_req");
        HONOR = 1'b1;
        step();
        HONOR = 1'b0;
        chk("t6_busy", BUSY, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6_busy_rst", BUSY, 1'b0);
        chk("t6_sel_rst", INCR_SEL, 2'b00);
        chk("t6_vec_rst", VECTOR_REQ, 1'b0);
        chk("t6_pend_rst", PENDING, 4'b0000);
        chk("t6_pireq_rst", PI_REQ, 7'b0);
        chk("t6_intr_rst", INTERRUPT_REQ, 1'b0);
        chk("t6_lost_rst", LOST, 1'b0);
        step();
        RESET_N = 1'b1;
        step(); step();
        chk("t6_post_intr", INTERRUPT_REQ, 1'b0);
        chk("t6_post_busy", BUSY, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
